// File: rtl/nn_pkg.sv
// Shared definitions for the neural-network datapath blocks.
//   serState_t : serializer FSM states.
//   CNT_W      : width of a counter that indexes 0..n-1 (at least 1 bit).
//   lane_lo    : low bit offset of lane `lane` in a flattened bus of `width`-bit lanes.
package nn_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } serState_t;

  function automatic int unsigned CNT_W(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned lane_lo(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/ser_capture_bank.sv
// Capture bank for layer_serializer: one word register and one flag per neuron lane.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   lane_data     : flattened neuron outputs, lane i at [i*dataWidth +: dataWidth]
//   lane_valid    : per-lane one-cycle valid strobes
//   clear         : empties the bank (transfer to the send buffer happens on this edge)
//   cap_data      : flattened captured words
//   cap_flag      : per-lane "word held" flags
//   full          : all flags set
//   overflow      : sticky, set when a lane strobes while its flag is already set
module ser_capture_bank
  import nn_pkg::*;
#(
  parameter int unsigned numNeuron = 30,
  parameter int unsigned dataWidth = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [numNeuron*dataWidth-1:0] lane_data,
  input  logic [numNeuron-1:0]           lane_valid,
  input  logic                           clear,
  output logic [numNeuron*dataWidth-1:0] cap_data,
  output logic [numNeuron-1:0]           cap_flag,
  output logic                           full,
  output logic                           overflow
);

  logic [numNeuron-1:0][dataWidth-1:0] data_q;
  logic [numNeuron-1:0]                flag_q, flag_d;
  logic [numNeuron-1:0]                load;
  logic                                ovf_q, ovf_d;

  always_comb begin
    flag_d = flag_q;
    ovf_d  = ovf_q;
    load   = '0;
    for (int i = 0; i < int'(numNeuron); i++) begin
      if (clear) begin
        // A strobe on the clearing edge belongs to the next vector, not an overflow.
        flag_d[i] = lane_valid[i];
        load[i]   = lane_valid[i];
      end else if (lane_valid[i]) begin
        if (flag_q[i]) begin
          ovf_d = 1'b1;
        end else begin
          flag_d[i] = 1'b1;
          load[i]   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      flag_q <= flag_d;
      ovf_q  <= ovf_d;
    end
  end

  // Data words are not reset; the flags alone say what is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(numNeuron); i++) begin
      if (load[i]) begin
        data_q[i] <= lane_data[lane_lo(i, dataWidth) +: dataWidth];
      end
    end
  end

  assign cap_data = data_q;
  assign cap_flag = flag_q;
  assign full     = &flag_q;
  assign overflow = ovf_q;

endmodule

// File: rtl/layer_serializer.sv
// Collects one word per neuron of a layer and streams the vector, in lane order, one word per
// cycle toward the next layer. Capture and send are double-buffered so collection of the next
// vector overlaps sending of the current one; back-to-back vectors stream without a gap.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   nOutput       : flattened neuron outputs, lane i at [i*dataWidth +: dataWidth]
//   nOutputValid  : per-lane one-cycle valid strobes
//   mOutput       : serial output word (registered)
//   mOutputValid  : qualifies mOutput (registered)
//   mOutputLast   : marks word numNeuron-1 of each vector (registered)
//   busy          : sending, or any word captured
//   overflow      : sticky, a lane strobed again before its word was taken
module layer_serializer
  import nn_pkg::*;
#(
  parameter int unsigned numNeuron = 30,
  parameter int unsigned dataWidth = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [numNeuron*dataWidth-1:0] nOutput,
  input  logic [numNeuron-1:0]           nOutputValid,
  output logic [dataWidth-1:0]           mOutput,
  output logic                           mOutputValid,
  output logic                           mOutputLast,
  output logic                           busy,
  output logic                           overflow
);

  localparam int unsigned   IdxW    = CNT_W(numNeuron);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(numNeuron - 1);
  localparam logic          OneWord = (numNeuron == 1);

  logic [numNeuron*dataWidth-1:0]      cap_data;
  logic [numNeuron-1:0]                cap_flag;
  logic                                full;
  logic                                xfer;

  logic [numNeuron-1:0][dataWidth-1:0] send_data_q;
  serState_t                           state_q, state_d;
  logic [IdxW-1:0]                     idx_q, idx_d, idx_inc;
  logic [dataWidth-1:0]                out_q, out_d;
  logic                                valid_q, valid_d;
  logic                                last_q, last_d;

  ser_capture_bank #(
    .numNeuron(numNeuron),
    .dataWidth(dataWidth)
  ) u_capture (
    .clk       (clk),
    .rst       (rst),
    .lane_data (nOutput),
    .lane_valid(nOutputValid),
    .clear     (xfer),
    .cap_data  (cap_data),
    .cap_flag  (cap_flag),
    .full      (full),
    .overflow  (overflow)
  );

  assign idx_inc = idx_q + IdxW'(1);

  // xfer: move the capture bank into the send buffer and start word 0 on the same edge, so
  // the output register already holds word 0 when the state reads SEND.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    out_d   = out_q;
    valid_d = 1'b0;
    last_d  = 1'b0;
    xfer    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (full) begin
          xfer    = 1'b1;
          state_d = SEND;
          idx_d   = '0;
          out_d   = cap_data[lane_lo(0, dataWidth) +: dataWidth];
          valid_d = 1'b1;
          last_d  = OneWord;
        end
      end
      SEND: begin
        if (idx_q == LastIdx) begin
          if (full) begin
            xfer    = 1'b1;
            idx_d   = '0;
            out_d   = cap_data[lane_lo(0, dataWidth) +: dataWidth];
            valid_d = 1'b1;
            last_d  = OneWord;
          end else begin
            state_d = IDLE;
            idx_d   = '0;
            out_d   = '0;
          end
        end else begin
          idx_d   = idx_inc;
          out_d   = send_data_q[idx_inc];
          valid_d = 1'b1;
          last_d  = (idx_inc == LastIdx);
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
        out_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (xfer) begin
      send_data_q <= cap_data;
    end
  end

  assign mOutput      = out_q;
  assign mOutputValid = valid_q;
  assign mOutputLast  = last_q;
  assign busy         = (state_q == SEND) | (|cap_flag);

endmodule

// File: tb/tb_layer_serializer.sv
module tb_layer_serializer;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk;
  logic           rst;
  logic [N*W-1:0] nOutput;
  logic [N-1:0]   nOutputValid;
  logic [W-1:0]   mOutput;
  logic           mOutputValid;
  logic           mOutputLast;
  logic           busy;
  logic           overflow;

  layer_serializer #(
    .numNeuron(N),
    .dataWidth(W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .nOutput     (nOutput),
    .nOutputValid(nOutputValid),
    .mOutput     (mOutput),
    .mOutputValid(mOutputValid),
    .mOutputLast (mOutputLast),
    .busy        (busy),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   run = 0;
  int   last_run = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N*W-1:0] mk(input logic [31:0] l0, input logic [31:0] l1,
                                        input logic [31:0] l2, input logic [31:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic push_vec(input logic [31:0] w0, input logic [31:0] w1,
                          input logic [31:0] w2, input logic [31:0] w3);
    exp_q.push_back('{data: w0, last: 1'b0});
    exp_q.push_back('{data: w1, last: 1'b0});
    exp_q.push_back('{data: w2, last: 1'b0});
    exp_q.push_back('{data: w3, last: 1'b1});
  endtask

  // Called just after a rising edge; the strobe is sampled on the next edge and the task
  // returns just after that edge.
  task automatic drive(input logic [N-1:0] v, input logic [N*W-1:0] d);
    nOutputValid = v;
    nOutput      = d;
    @(posedge clk);
    #1;
    nOutputValid = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every valid output word is matched against the head of exp_q.
  always @(negedge clk) begin
    if (mOutputValid) begin
      run++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_word: got 0x%0h with no word expected at %0t", mOutput, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("word_data", mOutput, e.data);
        chk("word_last", {31'b0, mOutputLast}, {31'b0, e.last});
      end
    end else begin
      if (run != 0) last_run = run;
      run = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1);
  end

  initial begin
    rst          = 1'b1;
    nOutput      = '0;
    nOutputValid = '0;
    #12;
    chk("rst_valid", {31'b0, mOutputValid}, 32'd0);
    chk("rst_last", {31'b0, mOutputLast}, 32'd0);
    chk("rst_data", mOutput, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_ovf", {31'b0, overflow}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Staggered valids, lane order 2,0,3,1.
    push_vec(32'h00, 32'h10, 32'h20, 32'h30);
    drive(4'b0100, mk(0, 0, 32'h20, 0));
    chk("stag_busy", {31'b0, busy}, 32'd1);
    drive(4'b0001, mk(32'h00, 0, 0, 0));
    drive(4'b1000, mk(0, 0, 0, 32'h30));
    drive(4'b0010, mk(0, 32'h10, 0, 0));
    chk("lat_not_yet", {31'b0, mOutputValid}, 32'd0);
    idle(1);
    chk("lat_word0_valid", {31'b0, mOutputValid}, 32'd1);
    chk("lat_word0_data", mOutput, 32'h00);
    idle(6);
    chk("stag_drained", exp_q.size(), 32'd0);
    chk("stag_run", last_run, 32'd4);
    chk("stag_idle_busy", {31'b0, busy}, 32'd0);

    // Simultaneous valids; busy from the capture edge through the last word.
    push_vec(5, 6, 7, 8);
    drive(4'b1111, mk(5, 6, 7, 8));
    for (int k = 0; k <= 5; k++) begin
      chk($sformatf("sim_busy%0d", k), {31'b0, busy}, (k < 5) ? 32'd1 : 32'd0);
      if (k < 5) idle(1);
    end
    idle(1);
    chk("sim_drained", exp_q.size(), 32'd0);
    chk("sim_run", last_run, 32'd4);

    // Back-to-back: second vector collected while the first is sent; lane 0 of the second
    // vector strobes on the transfer edge.
    push_vec(32'h100, 32'h101, 32'h102, 32'h103);
    push_vec(32'h200, 32'h201, 32'h202, 32'h203);
    drive(4'b1111, mk(32'h100, 32'h101, 32'h102, 32'h103));
    drive(4'b0001, mk(32'h200, 0, 0, 0));
    drive(4'b0010, mk(0, 32'h201, 0, 0));
    drive(4'b1100, mk(0, 0, 32'h202, 32'h203));
    idle(10);
    chk("b2b_drained", exp_q.size(), 32'd0);
    chk("b2b_run", last_run, 32'd8);
    chk("b2b_no_ovf", {31'b0, overflow}, 32'd0);

    // Overflow: lane 1 twice; first word kept.
    drive(4'b0010, mk(0, 32'hAA, 0, 0));
    chk("ovf_first", {31'b0, overflow}, 32'd0);
    drive(4'b0010, mk(0, 32'hBB, 0, 0));
    chk("ovf_rise", {31'b0, overflow}, 32'd1);
    push_vec(32'h11, 32'hAA, 32'h22, 32'h33);
    drive(4'b1101, mk(32'h11, 0, 32'h22, 32'h33));
    idle(7);
    chk("ovf_drained", exp_q.size(), 32'd0);
    chk("ovf_sticky", {31'b0, overflow}, 32'd1);

    // Reset while word 2 is on the output; only words 0 and 1 should be seen.
    exp_q.push_back('{data: 32'h50, last: 1'b0});
    exp_q.push_back('{data: 32'h51, last: 1'b0});
    drive(4'b1111, mk(32'h50, 32'h51, 32'h52, 32'h53));
    idle(3);
    chk("pre_rst_word2", mOutput, 32'h52);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", {31'b0, mOutputValid}, 32'd0);
    chk("mid_rst_data", mOutput, 32'd0);
    chk("mid_rst_last", {31'b0, mOutputLast}, 32'd0);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_ovf", {31'b0, overflow}, 32'd0);
    chk("mid_rst_drained", exp_q.size(), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    push_vec(32'h60, 32'h61, 32'h62, 32'h63);
    drive(4'b1111, mk(32'h60, 32'h61, 32'h62, 32'h63));
    idle(7);
    chk("post_rst_drained", exp_q.size(), 32'd0);
    chk("post_rst_run", last_run, 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/layer_serializer.md
# layer_serializer

Collects the parallel outputs of one layer of `neuron` instances and re-emits them as a serial word stream for the next layer's `mInput`/`mInputValid` port. Each neuron raises its own `mOutputValid` independently. The block captures one word per neuron, then streams the full vector in neuron-index order, one word per cycle. Capture and send are double-buffered, so the next vector can be collected while the current one is still being sent.

## Interface
- `numNeuron`, 30: neurons in the source layer; also the number of words per output vector.
- `dataWidth`, 32: width of each neuron output word.
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `nOutput` in `numNeuron*dataWidth`: neuron outputs. Lane i occupies bits `[i*dataWidth +: dataWidth]`.
- `nOutputValid` in `numNeuron`: per-lane valid. Bit i is a one-cycle strobe from neuron i.
- `mOutput` out `dataWidth`: serial data toward the next layer's `mInput`.
- `mOutputValid` out 1: qualifies `mOutput`.
- `mOutputLast` out 1: high with the final word (index `numNeuron-1`) of each vector.
- `busy` out 1: high while in SEND or while any capture flag is set.
- `overflow` out 1: sticky error flag, cleared only by `rst`.

## Operation
- **Capture bank:** `capData[numNeuron]` and `capFlag[numNeuron]`.
  - On an edge with `nOutputValid[i]`=1 and `capFlag[i]`=0, store the lane word and set the flag.
  - If `nOutputValid[i]`=1 while `capFlag[i]`=1, ignore the word, keep the stored value, and set `overflow`.
- **Full condition:** `full` = all `capFlag` bits set. This is a registered condition; flags set on the same edge count from the next cycle.
- **Send state machine:**
  - IDLE: if `full`, copy `capData` into `sendData`, clear all `capFlag`, set `idx`=0, go to SEND.
  - SEND: drive `mOutput`=`sendData[idx]` with `mOutputValid`=1, and increment `idx` each edge.
    - At `idx`=`numNeuron-1` with `full`=1: reload `sendData`, clear flags, set `idx`=0, stay in SEND. This gives a gap-free back-to-back stream.
    - At `idx`=`numNeuron-1` with `full`=0: go to IDLE.
- **Flag clear vs. new valid:** a `nOutputValid[i]` arriving on the edge where the flags are cleared by a transfer is captured into the new vector. The flag ends at 1 and no overflow is raised.
- **While `full` and waiting for SEND:** further valids on any lane raise `overflow` and are dropped.
- **No backpressure:** the downstream neuron always accepts, matching the neuron input protocol.
- **Counter:** `idx` is `$clog2(numNeuron)` bits wide, with no wrap beyond `numNeuron-1`.
- **Arithmetic:** data passes through unmodified, with no sign or width change.

## Timing
- **Reset values:** state=IDLE, `idx`=0, `capFlag`=0, `mOutput`=0, `mOutputValid`=0, `mOutputLast`=0, `busy`=0, `overflow`=0. Data banks are not reset.
- **Reset mid-stream:** outputs drop to reset values asynchronously. A partially captured or partially sent vector is discarded.
- **Latency, idle case:** last lane valid sampled at edge E, `full` true after E, transfer at E+1. Word 0 is valid after E+1, word k after E+1+k, and `mOutputLast` after E+numNeuron.
- **Stream shape:** `mOutputValid` stays high for exactly `numNeuron` consecutive cycles per vector. Back-to-back vectors give no idle cycle between a Last word and the next word 0.
- **Registered outputs:** `mOutput`, `mOutputValid` and `mOutputLast` are registers with no combinational path from inputs.
- **Overflow:** `overflow` rises one edge after the offending valid.

## Structure
- **Shared package `nn_pkg`:**
  - `serState_t` enum {IDLE, SEND}.
  - A lane-slice helper function.
  - A `CNT_W(numNeuron)` width constant function.
- **Sub-module `ser_capture_bank`:** holds `capData`/`capFlag`, the per-lane overflow detection and the `full` output. It has a clear input driven by the state machine.
- **Top-level `layer_serializer`:** contains the state machine, the `sendData` register and the output registers.

## Test plan
- **Single vector, staggered valids:** `numNeuron`=4, lanes pulse in order 2,0,3,1 with values 0x20,0x00,0x30,0x10.
  - Expect 0x00,0x10,0x20,0x30 on consecutive cycles starting 2 edges after lane 1's valid.
  - `mOutputLast` is high only with 0x30.
- **Simultaneous valids:** all 4 lanes valid on one edge with i+5.
  - Expect 5,6,7,8 starting 2 edges later.
  - `busy`=1 from the capture edge until after the last word.
- **Back-to-back vectors:** the second vector completes during SEND of the first.
  - Expect 8 consecutive valid cycles with no gap.
  - `mOutputLast` is high on cycles 4 and 8.
- **Overflow:** lane 1 pulses twice, 0xAA then 0xBB, before the vector is full.
  - Expect lane 1 to stream 0xAA and `overflow`=1 thereafter.
  - A lane valid on the transfer edge raises no overflow.
- **Reset mid-stream:** assert `rst` while word 2 is output.
  - Expect all outputs 0 immediately.
  - After release, a new full vector streams correctly from word 0.
